// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the core run controller
package cpu_ctrl_pkg;

  // Run sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } run_state_e;

  // Halt status reported to the host
  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_DONE    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORT   = 2'b11
  } run_status_e;

  // Opcode the control decoder turns into cpu_done
  localparam logic [5:0] DONE_OPCODE = 6'b111111;

  // Lets decoder-side logic share the same definition of "done"
  function automatic logic is_done_opcode(input logic [5:0] opcode);
    return opcode == DONE_OPCODE;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - core-cycle counter with clear and terminal flag
module run_cycle_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CYC_W-1:0] count,
  output logic             terminal
);

  localparam logic [CYC_W-1:0] LAST_VALUE = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CYC_W-1:0] CAP_VALUE  = CYC_W'(MAX_CYCLES);

  logic [CYC_W-1:0] count_q, count_d;

  // Clear wins over increment; the cap keeps the count from ever wrapping
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != CAP_VALUE)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == LAST_VALUE);

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - load/reset/run/halt sequencer around the single-cycle core
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int IMEM_AW    = 8,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               host_start,
  input  logic               host_abort,
  input  logic               host_load_valid,
  output logic               host_load_ready,
  input  logic [IMEM_AW-1:0] host_load_addr,
  input  logic [31:0]        host_load_data,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst_n,
  output logic               cpu_en,
  input  logic               cpu_done,
  output logic               busy,
  output logic [CYC_W-1:0]   cycle_count,
  output logic [1:0]         status
);

  localparam int              CLR_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYCLES - 1);

  run_state_e         state_q, state_d;
  run_status_e        status_q, status_d;
  logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               cpu_en_q, cpu_en_d;
  logic               imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]        imem_wdata_q, imem_wdata_d;

  logic               load_fire;
  logic               cnt_clear;
  logic               cnt_inc;
  logic               cnt_terminal;
  logic [CYC_W-1:0]   cnt_value;

  // The write port is only offered while the core is not executing
  assign host_load_ready = (state_q == IDLE) || (state_q == HALT);
  assign busy            = (state_q == CLR) || (state_q == RUN);
  assign load_fire       = host_load_valid && host_load_ready;

  run_cycle_counter #(
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .count    (cnt_value),
    .terminal (cnt_terminal)
  );

  // Next state, status, and core controls decoded from the state being entered
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    clr_cnt_d = clr_cnt_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE, HALT: begin
        if (host_start) begin
          state_d   = CLR;
          status_d  = ST_NONE;
          clr_cnt_d = '0;
          cnt_clear = 1'b1;
        end
      end
      CLR: begin
        if (host_abort) begin
          state_d  = HALT;
          status_d = ST_ABORT;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      RUN: begin
        // The exit cycle still counts as an executed core cycle
        cnt_inc = 1'b1;
        if (cpu_done) begin
          state_d  = HALT;
          status_d = ST_DONE;
        end else if (host_abort) begin
          state_d  = HALT;
          status_d = ST_ABORT;
        end else if (cnt_terminal) begin
          state_d  = HALT;
          status_d = ST_TIMEOUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registering these from state_d keeps them aligned with the state they describe
    cpu_rst_n_d = (state_d == RUN) || (state_d == HALT);
    cpu_en_d    = (state_d == RUN);
  end

  // Program-word write is replayed to instruction memory one cycle after acceptance
  always_comb begin
    imem_we_d    = load_fire;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    if (load_fire) begin
      imem_waddr_d = host_load_addr;
      imem_wdata_d = host_load_data;
    end
  end

  // Sequencer and output registers; reset drops the core back into reset at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      status_q     <= ST_NONE;
      clr_cnt_q    <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      clr_cnt_q    <= clr_cnt_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_en_q     <= cpu_en_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_waddr  = imem_waddr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign cpu_en      = cpu_en_q;
  assign cycle_count = cnt_value;
  assign status      = status_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - scoreboard bench for the core run controller
module tb_cpu_run_controller;

  localparam int IMEM_AW    = 8;
  localparam int CYC_W      = 32;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               host_start = 1'b0;
  logic               host_abort = 1'b0;
  logic               host_load_valid = 1'b0;
  logic               host_load_ready;
  logic [IMEM_AW-1:0] host_load_addr = '0;
  logic [31:0]        host_load_data = '0;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic               cpu_rst_n;
  logic               cpu_en;
  logic               cpu_done = 1'b0;
  logic               busy;
  logic [CYC_W-1:0]   cycle_count;
  logic [1:0]         status;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .IMEM_AW    (IMEM_AW),
    .CYC_W      (CYC_W),
    .RST_CYCLES (RST_CYCLES),
    .MAX_CYCLES (MAX_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .host_start      (host_start),
    .host_abort      (host_abort),
    .host_load_valid (host_load_valid),
    .host_load_ready (host_load_ready),
    .host_load_addr  (host_load_addr),
    .host_load_data  (host_load_data),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .cpu_rst_n       (cpu_rst_n),
    .cpu_en          (cpu_en),
    .cpu_done        (cpu_done),
    .busy            (busy),
    .cycle_count     (cycle_count),
    .status          (status)
  );

  typedef struct {
    logic [IMEM_AW-1:0] addr;
    logic [31:0]        data;
    int                 cyc;
  } wr_t;

  typedef struct {
    logic [1:0] st;
    int         cnt;
  } halt_t;

  wr_t   wr_q[$];
  halt_t halt_q[$];
  wr_t   wr_exp;
  halt_t halt_exp;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [IMEM_AW-1:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.cyc  = c;
    wr_q.push_back(w);
  endtask

  // Monitor: every memory write and every fall of busy is matched against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_imem_we", 1, 0);
        end else begin
          wr_exp = wr_q.pop_front();
          chk("imem_waddr", imem_waddr, wr_exp.addr);
          chk("imem_wdata", imem_wdata, wr_exp.data);
          chk("imem_we_cycle", cyc, wr_exp.cyc);
        end
      end
      if (busy_prev && !busy) begin
        if (halt_q.size() == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          halt_exp = halt_q.pop_front();
          chk("halt_status", status, halt_exp.st);
          chk("halt_cycle_count", cycle_count, halt_exp.cnt);
          chk("halt_cpu_en", cpu_en, 0);
          chk("halt_cpu_rst_n", cpu_rst_n, 1);
        end
      end
    end
    busy_prev = busy;
  end

  // Reference outcome of a run: the earliest event wins, ties resolved done > abort > timeout
  task automatic model_run(input int done_at, input int abort_at, input bit clr_abort,
                           output logic [1:0] st, output int end_k);
    if (clr_abort) begin
      st    = 2'b11;
      end_k = 0;
    end else begin
      end_k = MAX_CYCLES;
      if (done_at > 0 && done_at < end_k) end_k = done_at;
      if (abort_at > 0 && abort_at < end_k) end_k = abort_at;
      if (done_at == end_k) st = 2'b01;
      else if (abort_at == end_k) st = 2'b11;
      else st = 2'b10;
    end
  endtask

  task automatic do_run(input int done_at, input int abort_at, input bit clr_abort,
                        input bit start_load, input logic [IMEM_AW-1:0] load_addr,
                        input bit noise);
    logic [1:0] st;
    int         end_k;
    halt_t      h;
    model_run(done_at, abort_at, clr_abort, st, end_k);
    h.st  = st;
    h.cnt = end_k;
    halt_q.push_back(h);

    host_start = 1'b1;
    if (start_load) begin
      host_load_valid = 1'b1;
      host_load_addr  = load_addr;
      host_load_data  = $urandom;
      chk("start_load_ready", host_load_ready, 1);
      expect_write(host_load_addr, host_load_data, cyc + 1);
    end
    step();
    host_start      = 1'b0;
    host_load_valid = 1'b0;

    chk("clr1_cpu_rst_n", cpu_rst_n, 0);
    chk("clr1_cpu_en", cpu_en, 0);
    chk("clr1_busy", busy, 1);
    chk("clr1_status", status, 0);
    chk("clr1_cycle_count", cycle_count, 0);
    if (noise) cpu_done = 1'($urandom_range(0, 1));
    step();
    cpu_done = 1'b0;
    chk("clr2_cpu_rst_n", cpu_rst_n, 0);

    if (clr_abort) begin
      host_abort = 1'b1;
      step();
      host_abort = 1'b0;
    end else begin
      step();
      for (int k = 1; k <= end_k; k++) begin
        chk("run_cpu_rst_n", cpu_rst_n, 1);
        chk("run_cpu_en", cpu_en, 1);
        chk("run_cycle_count", cycle_count, k - 1);
        cpu_done   = (k == done_at);
        host_abort = (k == abort_at);
        if (noise) begin
          host_start      = 1'($urandom_range(0, 1));
          host_load_valid = 1'($urandom_range(0, 1));
          host_load_addr  = IMEM_AW'($urandom);
          host_load_data  = $urandom;
          chk("run_load_ready", host_load_ready, 0);
        end
        step();
      end
      cpu_done        = 1'b0;
      host_abort      = 1'b0;
      host_start      = 1'b0;
      host_load_valid = 1'b0;
    end

    // First HALT cycle: abort and done must both be ignored
    host_abort = 1'b1;
    cpu_done   = 1'b1;
    step();
    host_abort = 1'b0;
    cpu_done   = 1'b0;
    chk("halt_hold_status", status, st);
    chk("halt_hold_count", cycle_count, end_k);
    chk("halt_hold_ready", host_load_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[3];
    int          d_at;
    int          a_at;

    // Reset values
    repeat (3) step();
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_waddr", imem_waddr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_status", status, 0);
    chk("rst_ready", host_load_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back program load
    prog[0] = 32'h20080005;
    prog[1] = 32'h2108FFFF;
    prog[2] = 32'hFC000000;
    for (int i = 0; i < 3; i++) begin
      host_load_valid = 1'b1;
      host_load_addr  = IMEM_AW'(i);
      host_load_data  = prog[i];
      chk("load_ready", host_load_ready, 1);
      expect_write(host_load_addr, host_load_data, cyc + 1);
      step();
    end
    host_load_valid = 1'b0;
    step();

    // Start together with a load, done in the 7th run cycle
    do_run(7, 0, 1'b0, 1'b1, 8'd3, 1'b0);
    // Timeout
    do_run(0, 0, 1'b0, 1'b0, 8'd0, 1'b0);
    // Done and abort on the timeout cycle
    do_run(MAX_CYCLES, MAX_CYCLES, 1'b0, 1'b0, 8'd0, 1'b0);
    // Abort while the core is held in reset
    do_run(0, 0, 1'b1, 1'b0, 8'd0, 1'b0);
    // Abort versus timeout on the same cycle
    do_run(0, MAX_CYCLES, 1'b0, 1'b0, 8'd0, 1'b1);

    // Randomized runs with ignored starts and refused loads during RUN
    for (int r = 0; r < 10; r++) begin
      d_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      a_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      do_run(d_at, a_at, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
             IMEM_AW'($urandom), 1'b1);
    end

    // Loading is allowed again from HALT
    for (int i = 0; i < 2; i++) begin
      host_load_valid = 1'b1;
      host_load_addr  = IMEM_AW'($urandom);
      host_load_data  = $urandom;
      expect_write(host_load_addr, host_load_data, cyc + 1);
      step();
    end
    host_load_valid = 1'b0;
    step();

    // Reset in the middle of a run
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    repeat (3) step();
    chk("pre_reset_cpu_en", cpu_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_cpu_rst_n", cpu_rst_n, 0);
    chk("midrun_rst_cpu_en", cpu_en, 0);
    chk("midrun_rst_status", status, 0);
    chk("midrun_rst_ready", host_load_ready, 1);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_count", cycle_count, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_cpu_rst_n", cpu_rst_n, 0);

    repeat (3) step();
    chk("write_queue_drained", wr_q.size(), 0);
    chk("halt_queue_drained", halt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
